// File: rtl/adc_word_serializer.sv
// Parallel-to-serial shifter for ADC sample words: one word per handshake, CLK_DIV clocks per bit, channel/frame markers.
// Bit 0 appears the cycle after the handshake; in_ready is high only in IDLE or the last cycle of a word.
module adc_word_serializer #(
   parameter int DATA_W     = 16,
   parameter int CHANNELS   = 8,
   parameter int CLK_DIV    = 4,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              frame_rst,
   output logic              serial_data_out,
   output logic              bit_strobe,
   output logic              frame_sync,
   output logic              word_done,
   output logic [CH_W-1:0]   chan_idx,
   output logic              busy
);

   localparam int BC_W = $clog2(DATA_W);
   localparam int DV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
   localparam logic [DV_W-1:0] DIV_LAST = DV_W'(CLK_DIV - 1);
   localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [CH_W-1:0]   chan_q, chan_d;
   logic              sdo_q, sdo_d;
   logic              strobe_q, strobe_d;
   logic              fsync_q, fsync_d;

   logic              bit_end, last_cyc, load;
   logic [DATA_W-1:0] shifted;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   assign bit_end  = (state_q == S_SHIFT) && (div_cnt_q == DIV_LAST);
   assign last_cyc = bit_end && (bit_cnt_q == BIT_LAST);
   assign in_ready = reset && ((state_q == S_IDLE) || last_cyc);
   assign load     = in_valid && in_ready;
   assign shifted  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      sdo_d     = sdo_q;
      strobe_d  = 1'b0;
      fsync_d   = 1'b0;

      // frame_rst wins over the word_done increment
      if (frame_rst)
         chan_d = '0;
      else if (last_cyc)
         chan_d = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
      else
         chan_d = chan_q;

      if (load) begin
         state_d   = S_SHIFT;
         shreg_d   = in_data;
         bit_cnt_d = '0;
         div_cnt_d = '0;
         sdo_d     = first_bit(in_data);
         strobe_d  = 1'b1;
         fsync_d   = (chan_d == '0);
      end else if (last_cyc) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         div_cnt_d = '0;
         sdo_d     = IDLE_LEVEL;
      end else if (bit_end) begin
         shreg_d   = shifted;
         bit_cnt_d = bit_cnt_q + 1'b1;
         div_cnt_d = '0;
         sdo_d     = first_bit(shifted);
         strobe_d  = 1'b1;
      end else if (state_q == S_SHIFT) begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         div_cnt_q <= '0;
         chan_q    <= '0;
         sdo_q     <= IDLE_LEVEL;
         strobe_q  <= 1'b0;
         fsync_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         chan_q    <= chan_d;
         sdo_q     <= sdo_d;
         strobe_q  <= strobe_d;
         fsync_q   <= fsync_d;
      end
   end

   assign serial_data_out = sdo_q;
   assign bit_strobe      = strobe_q;
   assign frame_sync      = fsync_q;
   assign word_done       = last_cyc;
   assign chan_idx        = chan_q;
   assign busy            = (state_q == S_SHIFT);

endmodule

// File: tb/tb_adc_word_serializer.sv
// Bench for two serializer configurations: default (LSB first, div 4, 8 channels, idle 0)
// and MSB first, div 1, 3 channels, idle 1; a stream monitor decodes words against a queued reference.
module tb_adc_word_serializer;
   localparam int DW = 16;

   typedef struct {
      logic [DW-1:0] data;
      int            chan;
      int            start;
   } exp_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [1:0]    vld   = '0;
   logic [1:0]    frst  = '0;
   logic [DW-1:0] dat [2];
   logic [1:0]    rdy, sdo, stb, fs, wd, bsy;
   logic [2:0]    ch_a;
   logic [1:0]    ch_b;

   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   // reference: cycles left in the word being shifted, and the channel counter
   int   rem[2];
   int   mchan[2];

   bit            m_act[2];
   int            m_bitn[2];
   int            m_ph[2];
   logic [DW-1:0] m_bits[2];
   exp_t          m_cur[2];

   adc_word_serializer u_a (
      .clk(clk), .reset(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
      .frame_rst(frst[0]), .serial_data_out(sdo[0]), .bit_strobe(stb[0]), .frame_sync(fs[0]),
      .word_done(wd[0]), .chan_idx(ch_a), .busy(bsy[0])
   );

   adc_word_serializer #(.DATA_W(DW), .CHANNELS(3), .CLK_DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_b (
      .clk(clk), .reset(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
      .frame_rst(frst[1]), .serial_data_out(sdo[1]), .bit_strobe(stb[1]), .frame_sync(fs[1]),
      .word_done(wd[1]), .chan_idx(ch_b), .busy(bsy[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cdiv(input int id); return (id == 0) ? 4 : 1; endfunction
   function automatic int nch(input int id);  return (id == 0) ? 8 : 3; endfunction
   function automatic bit msb(input int id);  return (id == 1); endfunction
   function automatic bit idl(input int id);  return (id == 1); endfunction
   function automatic int chan_of(input int id);
      return (id == 0) ? int'(ch_a) : int'(ch_b);
   endfunction

   function automatic int qsize(input int id);
      return (id == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t popq(input int id);
      if (id == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic chk(input string nm, input int id, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[u%0d] at cycle %0d: got 0x%0h, expected 0x%0h", nm, id, cyc, act, exp);
      end
   endtask

   // Stream monitor: rebuilds each word from the strobed bits and checks timing and markers.
   task automatic mon(input int id);
      logic [DW-1:0] w;
      bit            done;
      if (!rst_n) begin
         m_act[id] = 1'b0;
         if (id == 0) q0.delete(); else q1.delete();
      end else begin
         if (stb[id]) begin
            if (!m_act[id]) begin
               if (qsize(id) == 0) begin
                  chk("unexpected_word", id, 1, 0);
                  m_cur[id] = '{data: '0, chan: -1, start: -1};
               end else begin
                  m_cur[id] = popq(id);
                  chk("start_cycle", id, cyc, m_cur[id].start);
                  chk("chan_idx", id, chan_of(id), m_cur[id].chan);
                  chk("frame_sync", id, fs[id], (m_cur[id].chan == 0));
               end
               m_act[id]  = 1'b1;
               m_bitn[id] = 0;
               m_ph[id]   = 1;
            end else begin
               chk("bit_length", id, m_ph[id], cdiv(id));
               chk("frame_sync_mid", id, fs[id], 0);
               m_bitn[id]++;
               m_ph[id] = 1;
            end
            if (m_bitn[id] < DW) m_bits[id][m_bitn[id]] = sdo[id];
         end else if (m_act[id]) begin
            m_ph[id]++;
            chk("frame_sync_mid", id, fs[id], 0);
            if (m_bitn[id] < DW) chk("bit_hold", id, sdo[id], m_bits[id][m_bitn[id]]);
         end else begin
            chk("idle_level", id, sdo[id], idl(id));
            chk("frame_sync_idle", id, fs[id], 0);
         end
         chk("busy", id, bsy[id], m_act[id]);
         done = m_act[id] && (m_bitn[id] == DW - 1) && (m_ph[id] == cdiv(id));
         chk("word_done", id, wd[id], done);
         if (done) begin
            for (int i = 0; i < DW; i++) begin
               if (msb(id)) w[DW-1-i] = m_bits[id][i];
               else         w[i]      = m_bits[id][i];
            end
            chk("word_data", id, w, m_cur[id].data);
            m_act[id] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // One clock of stimulus on instance id; the reference decides acceptance and the expected word.
   task automatic step(input int id, input logic v, input logic [DW-1:0] d, input logic f, output bit acc);
      bit r;
      vld[id]  = v;
      dat[id]  = d;
      frst[id] = f;
      @(negedge clk);
      r = (rem[id] <= 1);
      chk("in_ready", id, rdy[id], r);
      if (f)                mchan[id] = 0;
      else if (rem[id] == 1) mchan[id] = (mchan[id] + 1) % nch(id);
      acc = v && r;
      if (acc) begin
         if (id == 0) q0.push_back('{data: d, chan: mchan[id], start: cyc + 1});
         else         q1.push_back('{data: d, chan: mchan[id], start: cyc + 1});
         rem[id] = DW * cdiv(id);
      end else if (rem[id] > 0) begin
         rem[id]--;
      end
      @(posedge clk);
      #1;
      vld[id]  = 1'b0;
      frst[id] = 1'b0;
   endtask

   task automatic idle(input int id, input int n);
      bit acc;
      repeat (n) step(id, 1'b0, '0, 1'b0, acc);
   endtask

   // Holds in_valid until taken; optionally raises frame_rst only on the accepting cycle.
   task automatic send(input int id, input logic [DW-1:0] d, input bit frst_on_accept);
      bit acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++)
         step(id, 1'b1, d, frst_on_accept && (rem[id] <= 1), acc);
      if (!acc) chk("send_timeout", id, 0, 1);
   endtask

   task automatic check_reset_vals();
      for (int id = 0; id < 2; id++) begin
         chk("rst_in_ready", id, rdy[id], 0);
         chk("rst_sdo", id, sdo[id], idl(id));
         chk("rst_strobe", id, stb[id], 0);
         chk("rst_frame_sync", id, fs[id], 0);
         chk("rst_word_done", id, wd[id], 0);
         chk("rst_busy", id, bsy[id], 0);
         chk("rst_chan", id, chan_of(id), 0);
      end
   endtask

   task automatic model_reset();
      for (int id = 0; id < 2; id++) begin
         rem[id]   = 0;
         mchan[id] = 0;
      end
   endtask

   task automatic random_run(input int id, input int n);
      bit acc;
      for (int i = 0; i < n; i++)
         step(id, ($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 63) == 0), acc);
   endtask

   initial begin
      bit acc;
      dat[0] = '0;
      dat[1] = '0;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_reset_vals();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single word, LSB first, then idle level
      send(0, 16'hA5C3, 1'b0);
      idle(0, 70);

      // restart frame, then nine back-to-back words across a frame boundary
      step(0, 1'b0, '0, 1'b1, acc);
      for (int k = 1; k <= 9; k++) send(0, DW'(k), 1'b0);
      idle(0, 70);

      // stall: a word offered mid-shift is refused, then taken on the last cycle
      send(0, 16'h3C5A, 1'b0);
      idle(0, 4);
      step(0, 1'b1, 16'hDEAD, 1'b0, acc);
      idle(0, 10);
      send(0, 16'hDEAD, 1'b0);
      idle(0, 70);

      // frame_rst coinciding with word_done of channel 3
      step(0, 1'b0, '0, 1'b1, acc);
      for (int k = 0; k < 4; k++) send(0, DW'(16'h1100 + k), 1'b0);
      send(0, 16'h5555, 1'b1);
      idle(0, 70);

      random_run(0, 400);
      idle(0, 70);

      // reset in cycle 20 of a word
      send(0, 16'h1234, 1'b0);
      idle(0, 19);
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      @(negedge clk);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(0, 16'hFFFF, 1'b0);
      idle(0, 70);

      // MSB first, one clock per bit
      send(1, 16'h8001, 1'b0);
      idle(1, 20);
      random_run(1, 300);
      idle(1, 20);

      for (int id = 0; id < 2; id++) begin
         chk("scoreboard_empty", id, qsize(id), 0);
         chk("monitor_idle", id, m_act[id], 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
